// File: rtl/reply_arbiter.sv
// reply_arbiter: three-way round-robin arbiter that merges requester byte
// streams into reply packets of at most MAX_LEN data bytes for the FX2.
// Ports: clk, reset (sync, active-high); req_data/req_rdy/req_last in,
// req_ack out; reply/reply_rdy/reply_end out, reply_ack in;
// grant_id (2'b11 = none) and sticky underrun out.
// Build option: define REPLY_ARB_HEADER_EN to prefix each packet with
// a header byte {4'hA, 2'b00, grant_id}.
module reply_arbiter #(
  parameter int unsigned MAX_LEN = 64,
  parameter logic [7:0]  PAD     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] req_data,
  input  logic [2:0]  req_rdy,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_ack,
  output logic [7:0]  reply,
  output logic        reply_rdy,
  input  logic        reply_ack,
  output logic        reply_end,
  output logic [1:0]  grant_id,
  output logic        underrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_LEN - 1);
  localparam logic [1:0] NO_GNT   = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic [1:0] rr_q, rr_d;
  logic [7:0] count_q, count_d;
  logic       underrun_q, underrun_d;

  logic [1:0] pick;
  logic [7:0] lane_byte;
  logic       lane_rdy;
  logic       lane_last;
  logic       data_end;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    pick = NO_GNT;
    unique case (rr_q)
      2'd0: begin
        if (req_rdy[1])      pick = 2'd1;
        else if (req_rdy[2]) pick = 2'd2;
        else if (req_rdy[0]) pick = 2'd0;
      end
      2'd1: begin
        if (req_rdy[2])      pick = 2'd2;
        else if (req_rdy[0]) pick = 2'd0;
        else if (req_rdy[1]) pick = 2'd1;
      end
      default: begin
        if (req_rdy[0])      pick = 2'd0;
        else if (req_rdy[1]) pick = 2'd1;
        else if (req_rdy[2]) pick = 2'd2;
      end
    endcase
  end

  // Granted lane mux; an idle grant id selects nothing.
  always_comb begin
    lane_byte = 8'h00;
    lane_rdy  = 1'b0;
    lane_last = 1'b0;
    unique case (grant_id_q)
      2'd0: begin
        lane_byte = req_data[7:0];
        lane_rdy  = req_rdy[0];
        lane_last = req_last[0];
      end
      2'd1: begin
        lane_byte = req_data[15:8];
        lane_rdy  = req_rdy[1];
        lane_last = req_last[1];
      end
      2'd2: begin
        lane_byte = req_data[23:16];
        lane_rdy  = req_rdy[2];
        lane_last = req_last[2];
      end
      default: ;
    endcase
  end

  // Packet ends on the requester's last byte or at the length cap.
  assign data_end = (lane_rdy & lane_last) | (count_q == LAST_CNT);

  // Outputs are held quiet while reset is asserted so an abandoned
  // packet never shows reply_end or a stray ack.
  always_comb begin
    reply     = 8'h00;
    reply_rdy = 1'b0;
    reply_end = 1'b0;
    req_ack   = 3'b000;
    if (!reset) begin
      unique case (state_q)
        HDR: begin
          reply_rdy = 1'b1;
          reply     = {4'hA, 2'b00, grant_id_q};
        end
        DATA: begin
          reply_rdy = 1'b1;
          reply     = lane_rdy ? lane_byte : PAD;
          reply_end = data_end;
          unique case (grant_id_q)
            2'd0:    req_ack = {2'b00, reply_ack & lane_rdy};
            2'd1:    req_ack = {1'b0, reply_ack & lane_rdy, 1'b0};
            2'd2:    req_ack = {reply_ack & lane_rdy, 2'b00};
            default: req_ack = 3'b000;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_d       = rr_q;
    count_d    = count_q;
    underrun_d = underrun_q;
    unique case (state_q)
      IDLE: begin
        if (pick != NO_GNT) begin
          grant_id_d = pick;
          rr_d       = pick;
          count_d    = 8'h00;
`ifdef REPLY_ARB_HEADER_EN
          state_d    = HDR;
`else
          state_d    = DATA;
`endif
        end
      end
      HDR: begin
`ifdef REPLY_ARB_HEADER_EN
        count_d = 8'h00;
        if (reply_ack) state_d = DATA;
`else
        state_d = IDLE;
`endif
      end
      DATA: begin
        if (reply_ack) begin
          // An underrun still consumes a slot: PAD counts as data.
          count_d = count_q + 8'h01;
          if (!lane_rdy) underrun_d = 1'b1;
          if (data_end)  state_d    = DONE;
        end
      end
      DONE: begin
        state_d    = IDLE;
        grant_id_d = NO_GNT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_id_q <= NO_GNT;
      rr_q       <= 2'd2;
      count_q    <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_q       <= rr_d;
      count_q    <= count_d;
      underrun_q <= underrun_d;
    end
  end

  assign grant_id = grant_id_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_reply_arbiter.sv
// tb_reply_arbiter: directed bench for reply_arbiter (MAX_LEN=4).
// Covers single packet, round-robin, truncation, underrun, reset.
module tb_reply_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] req_data;
  logic [2:0]  req_rdy;
  logic [2:0]  req_last;
  logic [2:0]  req_ack;
  logic [7:0]  reply;
  logic        reply_rdy;
  logic        reply_ack;
  logic        reply_end;
  logic [1:0]  grant_id;
  logic        underrun;

  int total = 0;
  int bad   = 0;

  reply_arbiter #(.MAX_LEN(4), .PAD(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .reply     (reply),
    .reply_rdy (reply_rdy),
    .reply_ack (reply_ack),
    .reply_end (reply_end),
    .grant_id  (grant_id),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hdr_skip(input logic [1:0] id);
`ifdef REPLY_ARB_HEADER_EN
    logic sv;
    sv = reply_ack;
    reply_ack = 1'b1;
    #1;
    chk("hdr_byte", {24'h0, reply}, {24'h0, 4'hA, 2'b00, id});
    chk("hdr_end", {31'h0, reply_end}, 32'h0);
    chk("hdr_ack", {29'h0, req_ack}, 32'h0);
    chk("hdr_rdy", {31'h0, reply_rdy}, 32'h1);
    tick();
    reply_ack = sv;
`else
    chk("no_hdr_gnt", {30'h0, grant_id}, {30'h0, id});
`endif
  endtask

  int n;
  int lens[3] = '{4, 4, 2};
  logic [1:0] rr_exp[4] = '{2'd0, 2'd1, 2'd2, 2'd0};

  initial begin
    reset     = 1'b1;
    req_data  = 24'h0;
    req_rdy   = 3'b111;
    req_last  = 3'b000;
    reply_ack = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_gnt", {30'h0, grant_id}, 32'h3);
    chk("rst_rdy", {31'h0, reply_rdy}, 32'h0);
    chk("rst_end", {31'h0, reply_end}, 32'h0);
    chk("rst_reply", {24'h0, reply}, 32'h0);
    chk("rst_ack", {29'h0, req_ack}, 32'h0);
    chk("rst_unr", {31'h0, underrun}, 32'h0);

    // Single packet from requester 1
    tick();
    reset    = 1'b0;
    req_rdy  = 3'b010;
    req_data = 24'h001100;
    #1;
    chk("p1_idle_rdy", {31'h0, reply_rdy}, 32'h0);
    chk("p1_idle_reply", {24'h0, reply}, 32'h0);
    tick();
    hdr_skip(2'd1);
    #1;
    chk("p1_gnt", {30'h0, grant_id}, 32'h1);
    chk("p1_rdy", {31'h0, reply_rdy}, 32'h1);
    chk("p1_b0", {24'h0, reply}, 32'h11);
    chk("p1_e0", {31'h0, reply_end}, 32'h0);
    chk("p1_a0", {29'h0, req_ack}, 32'h2);
    tick();
    req_data = 24'h002200;
    #1;
    chk("p1_b1", {24'h0, reply}, 32'h22);
    chk("p1_e1", {31'h0, reply_end}, 32'h0);
    tick();
    req_data = 24'h003300;
    req_last = 3'b010;
    #1;
    chk("p1_b2", {24'h0, reply}, 32'h33);
    chk("p1_e2", {31'h0, reply_end}, 32'h1);
    chk("p1_a2", {29'h0, req_ack}, 32'h2);
    tick();
    req_rdy  = 3'b000;
    req_last = 3'b000;
    #1;
    chk("p1_done_rdy", {31'h0, reply_rdy}, 32'h0);
    chk("p1_done_ack", {29'h0, req_ack}, 32'h0);
    tick();
    #1;
    chk("p1_idle_gnt", {30'h0, grant_id}, 32'h3);
    chk("p1_idle_rdy2", {31'h0, reply_rdy}, 32'h0);

    // Contention from reset: order 0,1,2,0
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    req_rdy  = 3'b111;
    req_last = 3'b111;
    req_data = 24'hC2B1A0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_idle_rdy", {31'h0, reply_rdy}, 32'h0);
      tick();
      hdr_skip(rr_exp[k]);
      #1;
      chk("rr_gnt", {30'h0, grant_id}, {30'h0, rr_exp[k]});
      chk("rr_end", {31'h0, reply_end}, 32'h1);
      chk("rr_ack", {29'h0, req_ack}, 32'h1 << rr_exp[k]);
      chk("rr_byte", {24'h0, reply},
          {24'h0, req_data[8*rr_exp[k] +: 8]});
      tick();
      if (k == 3) req_rdy = 3'b000;
      #1;
      chk("rr_done_rdy", {31'h0, reply_rdy}, 32'h0);
      chk("rr_done_ack", {29'h0, req_ack}, 32'h0);
      tick();
    end

    // Truncation at MAX_LEN=4 over a 10-byte stream
    req_rdy  = 3'b001;
    req_last = 3'b000;
    n = 1;
    for (int p = 0; p < 3; p++) begin
      tick();
      hdr_skip(2'd0);
      for (int j = 0; j < lens[p]; j++) begin
        req_data = {16'h0, 8'(n)};
        req_last = {2'b00, n == 10};
        #1;
        chk("tr_byte", {24'h0, reply}, n);
        chk("tr_end", {31'h0, reply_end}, {31'h0, j == lens[p] - 1});
        chk("tr_ack", {29'h0, req_ack}, 32'h1);
        tick();
        n++;
      end
      req_last = 3'b000;
      if (n > 10) req_rdy = 3'b000;
      #1;
      chk("tr_done_rdy", {31'h0, reply_rdy}, 32'h0);
      chk("tr_done_ack", {29'h0, req_ack}, 32'h0);
      tick();
    end

    // Underrun from requester 2
    req_rdy  = 3'b100;
    req_data = 24'h710000;
    #1;
    chk("un_pre", {31'h0, underrun}, 32'h0);
    tick();
    hdr_skip(2'd2);
    #1;
    chk("un_b0", {24'h0, reply}, 32'h71);
    chk("un_a0", {29'h0, req_ack}, 32'h4);
    tick();
    req_rdy = 3'b000;
    #1;
    chk("un_pad", {24'h0, reply}, 32'h00);
    chk("un_pad_ack", {29'h0, req_ack}, 32'h0);
    chk("un_pad_end", {31'h0, reply_end}, 32'h0);
    chk("un_pad_rdy", {31'h0, reply_rdy}, 32'h1);
    tick();
    req_rdy  = 3'b100;
    req_data = 24'h720000;
    req_last = 3'b100;
    #1;
    chk("un_flag", {31'h0, underrun}, 32'h1);
    chk("un_b2", {24'h0, reply}, 32'h72);
    chk("un_e2", {31'h0, reply_end}, 32'h1);
    tick();
    req_rdy  = 3'b000;
    req_last = 3'b000;
    tick();

    // Ack while idle is ignored
    #1;
    chk("idle_ack_rdy", {31'h0, reply_rdy}, 32'h0);
    chk("idle_ack_ack", {29'h0, req_ack}, 32'h0);
    chk("idle_unr", {31'h0, underrun}, 32'h1);

    // Stall, then reset after two bytes
    req_rdy   = 3'b010;
    req_data  = 24'h009100;
    reply_ack = 1'b0;
    tick();
    hdr_skip(2'd1);
    #1;
    chk("st_gnt", {30'h0, grant_id}, 32'h1);
    chk("st_byte", {24'h0, reply}, 32'h91);
    chk("st_ack", {29'h0, req_ack}, 32'h0);
    tick();
    #1;
    chk("st_hold", {24'h0, reply}, 32'h91);
    reply_ack = 1'b1;
    #1;
    chk("st_ack1", {29'h0, req_ack}, 32'h2);
    tick();
    req_data = 24'h009200;
    tick();
    req_data = 24'h009300;
    reset    = 1'b1;
    #1;
    chk("rs_end", {31'h0, reply_end}, 32'h0);
    chk("rs_rdy", {31'h0, reply_rdy}, 32'h0);
    chk("rs_ack", {29'h0, req_ack}, 32'h0);
    chk("rs_reply", {24'h0, reply}, 32'h0);
    tick();
    reset     = 1'b0;
    req_rdy   = 3'b000;
    reply_ack = 1'b0;
    #1;
    chk("rs_gnt", {30'h0, grant_id}, 32'h3);
    chk("rs_rdy2", {31'h0, reply_rdy}, 32'h0);
    chk("rs_end2", {31'h0, reply_end}, 32'h0);
    chk("rs_unr", {31'h0, underrun}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reply_arbiter.md
REPLY_ARBITER -- requirements
Module: reply_arbiter

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, maximum data bytes per reply packet (legal 1..255).
REQ-002 SHALL have parameter PAD, default 8'h00, byte sent when the granted requester underruns.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_data  input  24  three byte lanes; requester i on bits [8i+7:8i].
REQ-006 SHALL have port req_rdy  input  3  requester i has a valid byte on its lane.
REQ-007 SHALL have port req_last  input  3  requester i's current byte is its last; qualified by req_rdy[i].
REQ-008 SHALL have port req_ack  output  3  requester i's byte consumed this cycle.
REQ-009 SHALL have port reply  output  8  byte to the FX2 reply stream.
REQ-010 SHALL have port reply_rdy  output  1  reply packet pending or in progress.
REQ-011 SHALL have port reply_ack  input  1  FX2 side consumed reply this cycle.
REQ-012 SHALL have port reply_end  output  1  current reply byte ends the packet.
REQ-013 SHALL have port grant_id  output  2  index of the granted requester; 2'b11 when none.
REQ-014 SHALL have port underrun  output  1  sticky flag; set on any underrun.

Function
REQ-015 SHALL implement the states IDLE, HDR, DATA and DONE.
REQ-016 IDLE: if any req_rdy is set, SHALL grant round-robin, searching from (last granted + 1) mod 3, register grant_id, and go to HDR (macro on) or DATA (macro off).
REQ-017 SHALL update the round-robin pointer only on grant.
REQ-018 reply_rdy SHALL be 1 exactly in HDR and DATA; grant-to-reply_rdy latency SHALL be 1 cycle.
REQ-019 In DATA, reply SHALL equal the granted lane when req_rdy[grant] is set, else PAD; this path is combinational.
REQ-020 req_ack[grant] SHALL equal reply_ack & req_rdy[grant] in DATA; all other req_ack bits SHALL be 0.
REQ-021 In DATA, an 8-bit byte counter SHALL increment on each reply_ack and clear on entry to DATA.
REQ-022 reply_end SHALL equal (req_rdy[grant] & req_last[grant]) | (count == MAX_LEN-1) in DATA, and 0 elsewhere.
REQ-023 reply_ack & reply_end in DATA SHALL go to DONE.
REQ-024 On truncation at MAX_LEN, the requester's remaining bytes SHALL form a new packet at its next grant.
REQ-025 reply_ack & ~req_rdy[grant] in DATA SHALL set underrun and consume PAD as a data byte (count increments).
REQ-026 DONE SHALL last exactly 1 cycle with reply_rdy=0, then go to IDLE; no back-to-back packets.
REQ-027 reply_ack while reply_rdy=0 SHALL be ignored.
REQ-028 Requests arriving in DONE or mid-packet SHALL wait; simultaneous requests in IDLE SHALL resolve by round-robin.

Reset
REQ-029 reset SHALL force state IDLE, RR pointer so that req0 has highest priority, count 0, grant_id 2'b11, underrun 0.
REQ-030 During and after reset: req_ack, reply_rdy and reply_end SHALL be 0 and reply SHALL be 8'h00.
REQ-031 reset mid-packet SHALL abandon the packet without asserting reply_end.

Configuration
REQ-032 With macro REPLY_ARB_HEADER_EN defined: HDR SHALL emit one header byte {4'hA, 2'b00, grant_id}, with reply_end=0 and req_ack=0, advancing to DATA on reply_ack; the header does not count toward MAX_LEN.
REQ-033 Without REPLY_ARB_HEADER_EN: HDR SHALL be unreachable and IDLE SHALL go directly to DATA.

Verification
REQ-034 Single packet (macro off): req1 sends 0x11,0x22,0x33 (last on 0x33), reply_ack held high -> reply=11,22,33, reply_end only with 33, grant_id=1, then 1 cycle reply_rdy=0.
REQ-035 Contention: all three req_rdy set from reset, 1-byte packets that re-request each time -> grant order 0,1,2,0.
REQ-036 Truncation: MAX_LEN=4, req0 streams 10 bytes -> packets of 4, 4 and 2 bytes, with reply_end on bytes 4, 8 and 10.
REQ-037 Underrun: req2 drops req_rdy for 1 cycle mid-packet with reply_ack=1 -> one 8'h00 byte emitted, underrun=1 until reset.
REQ-038 Header (macro on): req2 sends 0x55 (last) -> reply=A2 then 55, req_ack[2] only with 55.
REQ-039 Reset in DATA after 2 bytes -> next cycle IDLE, grant_id=3, reply_rdy=0, no reply_end emitted.
